// File: rtl/ex_fp_sequencer_pkg.sv
// Shared encodings for the EX-stage FP sequencer: FSM states, latency classes,
// FPU op-select / operand-A codes and the RISC-V FP opcode fields it decodes.
package ex_fp_sequencer_pkg;

   typedef enum logic [1:0] {
      SEQ_IDLE = 2'd0,
      SEQ_REQ  = 2'd1,
      SEQ_WAIT = 2'd2,
      SEQ_DONE = 2'd3
   } seq_state_t;

   localparam logic [1:0] LATC_ADD  = 2'd0;
   localparam logic [1:0] LATC_MADD = 2'd1;
   localparam logic [1:0] LATC_CVT  = 2'd2;
   localparam logic [1:0] LATC_MISC = 2'd3;

   localparam logic [2:0] FPU_ADD  = 3'd0;
   localparam logic [2:0] FPU_SGNJ = 3'd1;
   localparam logic [2:0] FPU_MVXW = 3'd2;
   localparam logic [2:0] FPU_MVWX = 3'd3;
   localparam logic [2:0] FPU_CVT  = 3'd4;
   localparam logic [2:0] FPU_MADD = 3'd5;
   localparam logic [2:0] FPU_LW   = 3'd6;
   localparam logic [2:0] FPU_SW   = 3'd7;

   // Operand A comes from the FP register file or the integer path (x-reg / load data).
   localparam logic FP_A_FREG = 1'b0;
   localparam logic FP_A_XREG = 1'b1;

   localparam logic [6:0] OPC_OP_FP    = 7'b1010011;
   localparam logic [6:0] OPC_MADD     = 7'b1000011;
   localparam logic [6:0] OPC_LOAD_FP  = 7'b0000111;
   localparam logic [6:0] OPC_STORE_FP = 7'b0100111;

   localparam logic [6:0] F7_FADD     = 7'b0000000;
   localparam logic [6:0] F7_FSGNJ    = 7'b0010000;
   localparam logic [6:0] F7_FMV_X_W  = 7'b1110000;
   localparam logic [6:0] F7_FMV_W_X  = 7'b1111000;
   localparam logic [6:0] F7_FCVT_S_W = 7'b1101000;

endpackage

// File: rtl/ex_fp_sequencer_decode.sv
// Combinational decode of the EX instruction into FP-op attributes.
module fp_op_decode
   import ex_fp_sequencer_pkg::*;
(
   input  logic [31:0] inst,
   output logic        is_fp,
   output logic [2:0]  fpusel,
   output logic        fpa_sel,
   output logic [1:0]  lat_class
);

   logic [6:0] opcode;
   logic [6:0] funct7;
   logic [4:0] rs2;
   logic [2:0] funct3;
   logic [1:0] fmt;
   logic       unused_fields;

   assign opcode        = inst[6:0];
   assign funct7        = inst[31:25];
   assign rs2           = inst[24:20];
   assign funct3        = inst[14:12];
   assign fmt           = inst[26:25];
   assign unused_fields = ^{inst[19:15], inst[11:7]};

   always_comb begin
      is_fp     = 1'b0;
      fpusel    = FPU_ADD;
      fpa_sel   = FP_A_FREG;
      lat_class = LATC_MISC;
      case (opcode)
         OPC_OP_FP: begin
            case (funct7)
               F7_FADD: begin
                  is_fp     = 1'b1;
                  fpusel    = FPU_ADD;
                  lat_class = LATC_ADD;
               end
               F7_FSGNJ: if (funct3 == 3'b000 || funct3 == 3'b001 || funct3 == 3'b010) begin
                  is_fp  = 1'b1;
                  fpusel = FPU_SGNJ;
               end
               F7_FMV_X_W: if (rs2 == 5'd0 && funct3 == 3'b000) begin
                  is_fp  = 1'b1;
                  fpusel = FPU_MVXW;
               end
               F7_FMV_W_X: if (rs2 == 5'd0 && funct3 == 3'b000) begin
                  is_fp   = 1'b1;
                  fpusel  = FPU_MVWX;
                  fpa_sel = FP_A_XREG;
               end
               F7_FCVT_S_W: if (rs2 == 5'd0) begin
                  is_fp     = 1'b1;
                  fpusel    = FPU_CVT;
                  fpa_sel   = FP_A_XREG;
                  lat_class = LATC_CVT;
               end
               default: ;
            endcase
         end
         OPC_MADD: if (fmt == 2'b00) begin
            is_fp     = 1'b1;
            fpusel    = FPU_MADD;
            lat_class = LATC_MADD;
         end
         OPC_LOAD_FP: if (funct3 == 3'b010) begin
            is_fp   = 1'b1;
            fpusel  = FPU_LW;
            fpa_sel = FP_A_XREG;
         end
         OPC_STORE_FP: if (funct3 == 3'b010) begin
            is_fp  = 1'b1;
            fpusel = FPU_SW;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/ex_fp_sequencer.sv
// EX-stage FP sequencer: issues one FPU request per FP instruction, stalls EX until
// completion (fixed latency or response handshake with watchdog), cancels on flush.
module ex_fp_sequencer
   import ex_fp_sequencer_pkg::*;
#(
   parameter bit FIXED_LAT = 1'b1,
   parameter int LAT_ADD   = 3,
   parameter int LAT_MADD  = 5,
   parameter int LAT_CVT   = 2,
   parameter int LAT_MISC  = 1,
   parameter int TIMEOUT   = 16,
   parameter int CNT_W     = 5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] inst,
   input  logic        ex_new,
   input  logic        flush,
   input  logic        fpu_ready,
   input  logic        fpu_resp_valid,
   output logic        fpu_valid,
   output logic [2:0]  fpusel,
   output logic        fpa_sel,
   output logic        fp_stall,
   output logic        fp_result_valid,
   output logic        fpu_kill,
   output logic        timeout_err
);

   logic             is_fp;
   logic [2:0]       dec_sel;
   logic             dec_asel;
   logic [1:0]       dec_lat;
   logic [1:0]       lat_q;
   logic [CNT_W-1:0] lat_cnt;
   logic [CNT_W-1:0] cnt;
   logic             busy;
   logic             issue;
   seq_state_t       state;

   fp_op_decode u_decode (
      .inst      (inst),
      .is_fp     (is_fp),
      .fpusel    (dec_sel),
      .fpa_sel   (dec_asel),
      .lat_class (dec_lat)
   );

   assign issue    = ex_new & is_fp & ~flush;
   // busy mirrors REQ|WAIT as a register; rst gates the combinational issue term too.
   assign fp_stall = ~rst & (busy | issue);

   always_comb begin
      case (lat_q)
         LATC_ADD:  lat_cnt = CNT_W'(LAT_ADD);
         LATC_MADD: lat_cnt = CNT_W'(LAT_MADD);
         LATC_CVT:  lat_cnt = CNT_W'(LAT_CVT);
         default:   lat_cnt = CNT_W'(LAT_MISC);
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state           <= SEQ_IDLE;
         cnt             <= '0;
         fpusel          <= '0;
         fpa_sel         <= 1'b0;
         lat_q           <= LATC_ADD;
         fpu_valid       <= 1'b0;
         busy            <= 1'b0;
         fp_result_valid <= 1'b0;
         fpu_kill        <= 1'b0;
         timeout_err     <= 1'b0;
      end else begin
         fpu_valid       <= 1'b0;
         busy            <= 1'b0;
         fp_result_valid <= 1'b0;
         fpu_kill        <= 1'b0;
         case (state)
            SEQ_IDLE, SEQ_DONE: begin
               if (issue) begin
                  state     <= SEQ_REQ;
                  fpusel    <= dec_sel;
                  fpa_sel   <= dec_asel;
                  lat_q     <= dec_lat;
                  fpu_valid <= 1'b1;
                  busy      <= 1'b1;
               end else begin
                  state <= SEQ_IDLE;
               end
            end
            SEQ_REQ: begin
               if (flush) begin
                  state    <= SEQ_IDLE;
                  fpu_kill <= 1'b1;
               end else if (fpu_ready) begin
                  state <= SEQ_WAIT;
                  cnt   <= FIXED_LAT ? lat_cnt : CNT_W'(TIMEOUT);
                  busy  <= 1'b1;
               end else begin
                  fpu_valid <= 1'b1;
                  busy      <= 1'b1;
               end
            end
            SEQ_WAIT: begin
               // Flush outranks a same-cycle response or expiry.
               if (flush) begin
                  state    <= SEQ_IDLE;
                  fpu_kill <= 1'b1;
                  cnt      <= '0;
               end else if (!FIXED_LAT && fpu_resp_valid) begin
                  state           <= SEQ_DONE;
                  fp_result_valid <= 1'b1;
                  cnt             <= '0;
               end else if (cnt == CNT_W'(1)) begin
                  state           <= SEQ_DONE;
                  fp_result_valid <= 1'b1;
                  cnt             <= '0;
                  if (!FIXED_LAT) timeout_err <= 1'b1;
               end else begin
                  busy <= 1'b1;
                  if (cnt != '0) cnt <= cnt - CNT_W'(1);
               end
            end
            default: state <= SEQ_IDLE;
         endcase
      end
   end

   // A zero latency would leave WAIT with nothing to count down.
   assert property (@(posedge clk) disable iff (rst) (state == SEQ_WAIT) |-> (cnt != '0));

endmodule

// File: tb/tb_ex_fp_sequencer.sv
// Bench for ex_fp_sequencer: one fixed-latency and one handshake instance on shared stimulus.
module tb_ex_fp_sequencer;
   import ex_fp_sequencer_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] inst = '0;
   logic        ex_new = 1'b0, flush = 1'b0, fpu_ready = 1'b0, fpu_resp_valid = 1'b0;
   logic        f_valid, f_asel, f_stall, f_res, f_kill, f_to;
   logic        h_valid, h_asel, h_stall, h_res, h_kill, h_to;
   logic [2:0]  f_sel, h_sel;
   int          n_cmp = 0;
   int          n_err = 0;
   logic [4:0]  exp_q[$];
   logic [2:0]  res_q[$];

   always #5 clk = ~clk;

   ex_fp_sequencer #(.FIXED_LAT(1'b1)) dut_fix (
      .clk(clk), .rst(rst), .inst(inst), .ex_new(ex_new), .flush(flush),
      .fpu_ready(fpu_ready), .fpu_resp_valid(fpu_resp_valid), .fpu_valid(f_valid),
      .fpusel(f_sel), .fpa_sel(f_asel), .fp_stall(f_stall), .fp_result_valid(f_res),
      .fpu_kill(f_kill), .timeout_err(f_to));

   ex_fp_sequencer #(.FIXED_LAT(1'b0)) dut_hs (
      .clk(clk), .rst(rst), .inst(inst), .ex_new(ex_new), .flush(flush),
      .fpu_ready(fpu_ready), .fpu_resp_valid(fpu_resp_valid), .fpu_valid(h_valid),
      .fpusel(h_sel), .fpa_sel(h_asel), .fp_stall(h_stall), .fp_result_valid(h_res),
      .fpu_kill(h_kill), .timeout_err(h_to));

   function automatic logic [4:0] fvec();
      return {f_valid, f_stall, f_res, f_kill, f_to};
   endfunction

   function automatic logic [4:0] hvec();
      return {h_valid, h_stall, h_res, h_kill, h_to};
   endfunction

   task automatic do_reset();
      rst = 1'b1; ex_new = 1'b0; flush = 1'b0; fpu_ready = 1'b0; fpu_resp_valid = 1'b0; inst = '0;
      exp_q.delete(); res_q.delete();
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; inst = 32'h00208053; ex_new = 1'b1; fpu_ready = 1'b1; fpu_resp_valid = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if ({fvec(), f_sel, f_asel} !== 9'b0) begin
         n_err++; $display("FAIL reset_fix: got %b expected 0", {fvec(), f_sel, f_asel});
      end
      n_cmp++;
      if ({hvec(), h_sel, h_asel} !== 9'b0) begin
         n_err++; $display("FAIL reset_hs: got %b expected 0", {hvec(), h_sel, h_asel});
      end
      rst = 1'b0; ex_new = 1'b0; fpu_ready = 1'b0; fpu_resp_valid = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      n_cmp++;
      if ({fvec(), hvec()} !== 10'b0) begin
         n_err++; $display("FAIL reset_idle: got %b expected 0", {fvec(), hvec()});
      end
      @(posedge clk); #1;
   endtask

   task automatic test_fadd_fixed();
      logic [4:0] e;
      logic [2:0] r;
      do_reset();
      inst = 32'h00208053; fpu_ready = 1'b1;
      for (int c = 0; c < 8; c++) begin
         ex_new = (c == 0);
         exp_q.push_back({c == 1, c <= 4, c == 5, 1'b0, 1'b0});
         if (c == 0) res_q.push_back(FPU_ADD);
         @(negedge clk);
         e = exp_q.pop_front();
         n_cmp++;
         if (fvec() !== e) begin
            n_err++; $display("FAIL fadd_trace c%0d: got %b expected %b", c, fvec(), e);
         end
         if (f_valid) begin
            n_cmp++;
            if (f_sel !== FPU_ADD) begin
               n_err++; $display("FAIL fadd_sel c%0d: got %0d expected %0d", c, f_sel, FPU_ADD);
            end
         end
         if (f_res) begin
            r = (res_q.size() > 0) ? res_q.pop_front() : 3'bx;
            n_cmp++;
            if (f_sel !== r) begin
               n_err++; $display("FAIL fadd_result c%0d: got %0d expected %0d", c, f_sel, r);
            end
         end
         @(posedge clk); #1;
      end
      n_cmp++;
      if (res_q.size() != 0) begin
         n_err++; $display("FAIL fadd_pending: got %0d outstanding expected 0", res_q.size());
      end
      ex_new = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [4:0] e;
      logic [2:0] r;
      do_reset();
      inst = 32'h00208053; fpu_ready = 1'b1;
      for (int c = 0; c < 12; c++) begin
         ex_new = (c == 0 || c == 5);
         exp_q.push_back({c == 1 || c == 6, c <= 9, c == 5 || c == 10, 1'b0, 1'b0});
         if (ex_new) res_q.push_back(FPU_ADD);
         @(negedge clk);
         e = exp_q.pop_front();
         n_cmp++;
         if (fvec() !== e) begin
            n_err++; $display("FAIL b2b_trace c%0d: got %b expected %b", c, fvec(), e);
         end
         if (f_res) begin
            r = (res_q.size() > 0) ? res_q.pop_front() : 3'bx;
            n_cmp++;
            if (f_sel !== r) begin
               n_err++; $display("FAIL b2b_result c%0d: got %0d expected %0d", c, f_sel, r);
            end
         end
         @(posedge clk); #1;
      end
      n_cmp++;
      if (res_q.size() != 0) begin
         n_err++; $display("FAIL b2b_pending: got %0d outstanding expected 0", res_q.size());
      end
      ex_new = 1'b0;
   endtask

   task automatic test_latencies();
      logic [31:0] ti [8];
      logic [2:0]  ts [8];
      logic        ta [8];
      int          tl [8];
      int          w;
      ti = '{32'h00208053, 32'h20208053, 32'hE00100D3, 32'hF00100D3,
             32'hD00100D3, 32'h203100C3, 32'h00012087, 32'h00112027};
      ts = '{FPU_ADD, FPU_SGNJ, FPU_MVXW, FPU_MVWX, FPU_CVT, FPU_MADD, FPU_LW, FPU_SW};
      ta = '{FP_A_FREG, FP_A_FREG, FP_A_FREG, FP_A_XREG, FP_A_XREG, FP_A_FREG, FP_A_XREG, FP_A_FREG};
      tl = '{3, 1, 1, 1, 2, 5, 1, 1};
      for (int i = 0; i < 8; i++) begin
         do_reset();
         inst = ti[i]; fpu_ready = 1'b1; ex_new = 1'b1;
         @(posedge clk); #1;
         ex_new = 1'b0;
         @(negedge clk);
         n_cmp++;
         if ({f_valid, f_sel, f_asel} !== {1'b1, ts[i], ta[i]}) begin
            n_err++; $display("FAIL op%0d_req: got %b expected %b", i, {f_valid, f_sel, f_asel}, {1'b1, ts[i], ta[i]});
         end
         w = 0;
         do begin
            @(posedge clk); @(negedge clk);
            w++;
         end while (!f_res && w < 40);
         n_cmp++;
         if (w != tl[i] + 1) begin
            n_err++; $display("FAIL op%0d_latency: got %0d cycles after REQ expected %0d", i, w, tl[i] + 1);
         end
         @(posedge clk); #1;
      end
      do_reset();
      inst = 32'h00000033; ex_new = 1'b1; fpu_ready = 1'b1;
      @(negedge clk);
      n_cmp++;
      if ({f_stall, h_stall} !== 2'b00) begin
         n_err++; $display("FAIL nonfp_stall: got %b expected 00", {f_stall, h_stall});
      end
      @(posedge clk); #1;
      ex_new = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({f_valid, h_valid, f_stall, h_stall} !== 4'b0) begin
         n_err++; $display("FAIL nonfp_issue: got %b expected 0000", {f_valid, h_valid, f_stall, h_stall});
      end
      @(posedge clk); #1;
   endtask

   task automatic test_handshake_ready();
      logic [4:0] e;
      logic [2:0] r;
      do_reset();
      inst = 32'h00208053;
      for (int c = 0; c < 9; c++) begin
         ex_new = (c == 0); fpu_ready = (c >= 4); fpu_resp_valid = (c == 2 || c == 6);
         exp_q.push_back({c >= 1 && c <= 4, c <= 6, c == 7, 1'b0, 1'b0});
         if (c == 0) res_q.push_back(FPU_ADD);
         @(negedge clk);
         e = exp_q.pop_front();
         n_cmp++;
         if (hvec() !== e) begin
            n_err++; $display("FAIL hs_trace c%0d: got %b expected %b", c, hvec(), e);
         end
         if (h_valid) begin
            n_cmp++;
            if (h_sel !== FPU_ADD) begin
               n_err++; $display("FAIL hs_sel c%0d: got %0d expected %0d", c, h_sel, FPU_ADD);
            end
         end
         if (h_res) begin
            r = (res_q.size() > 0) ? res_q.pop_front() : 3'bx;
            n_cmp++;
            if (h_sel !== r) begin
               n_err++; $display("FAIL hs_result c%0d: got %0d expected %0d", c, h_sel, r);
            end
         end
         @(posedge clk); #1;
      end
      ex_new = 1'b0; fpu_resp_valid = 1'b0;
   endtask

   task automatic test_flush();
      logic [4:0] e;
      do_reset();
      inst = 32'h203100C3; fpu_ready = 1'b1;
      for (int c = 0; c < 8; c++) begin
         ex_new = (c == 0 || c == 5); flush = (c == 3 || c == 5); fpu_resp_valid = (c == 3);
         exp_q.push_back({c == 1, c <= 3, 1'b0, c == 4, 1'b0});
         @(negedge clk);
         e = exp_q.pop_front();
         n_cmp++;
         if (fvec() !== e) begin
            n_err++; $display("FAIL flush_fix c%0d: got %b expected %b", c, fvec(), e);
         end
         n_cmp++;
         if (hvec() !== e) begin
            n_err++; $display("FAIL flush_hs c%0d: got %b expected %b", c, hvec(), e);
         end
         @(posedge clk); #1;
      end
      ex_new = 1'b0; flush = 1'b0; fpu_resp_valid = 1'b0;
   endtask

   task automatic test_timeout();
      logic [4:0] e;
      do_reset();
      inst = 32'h00208053; fpu_ready = 1'b1;
      for (int c = 0; c < 26; c++) begin
         ex_new = (c == 0 || c == 20); fpu_resp_valid = (c == 23);
         exp_q.push_back({c == 1 || c == 21, c <= 17 || (c >= 20 && c <= 23),
                          c == 18 || c == 24, 1'b0, c >= 18});
         @(negedge clk);
         e = exp_q.pop_front();
         n_cmp++;
         if (hvec() !== e) begin
            n_err++; $display("FAIL timeout_trace c%0d: got %b expected %b", c, hvec(), e);
         end
         @(posedge clk); #1;
      end
      ex_new = 1'b0; fpu_resp_valid = 1'b0;
   endtask

   // Relies on timeout_err still being set from test_timeout.
   task automatic test_async_reset();
      inst = 32'h00208053; fpu_ready = 1'b1; ex_new = 1'b1;
      @(posedge clk); #1;
      ex_new = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      n_cmp++;
      if ({f_stall, h_stall, h_to} !== 3'b111) begin
         n_err++; $display("FAIL arst_pre: got %b expected 111", {f_stall, h_stall, h_to});
      end
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      n_cmp++;
      if ({fvec(), f_sel, f_asel, hvec(), h_sel, h_asel} !== 18'b0) begin
         n_err++; $display("FAIL arst_now: got %b expected 0", {fvec(), f_sel, f_asel, hvec(), h_sel, h_asel});
      end
      @(posedge clk); #1;
      rst = 1'b0; inst = 32'h00000033; ex_new = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         n_cmp++;
         if ({f_valid, f_stall, h_valid, h_stall, h_to} !== 5'b0) begin
            n_err++; $display("FAIL arst_add c%0d: got %b expected 0", c, {f_valid, f_stall, h_valid, h_stall, h_to});
         end
         @(posedge clk); #1;
         ex_new = 1'b0;
      end
   endtask

   initial begin
      test_reset();
      test_fadd_fixed();
      test_back_to_back();
      test_latencies();
      test_handshake_ready();
      test_flush();
      test_timeout();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion expected finish before 200000");
      $fatal(1);
   end

endmodule
